// File: rtl/rename_map_pkg.sv
// Shared definitions for the register rename map: parameter defaults,
// the per-lane output record and the identity-map initialiser.
package rename_map_pkg;

  localparam int RM_WIDTH  = 2;
  localparam int RM_NAREG  = 16;
  localparam int RM_PTAG_W = 5;
  localparam int RM_TTAG_W = 4;

  // Per-lane rename result, sized for the default tag widths.
  typedef struct packed {
    logic [RM_PTAG_W-1:0] p_rs1;
    logic [RM_PTAG_W-1:0] p_rs2;
    logic [RM_PTAG_W-1:0] p_rd;
    logic [RM_PTAG_W-1:0] rd_stale;
    logic [RM_TTAG_W-1:0] p_t;
    logic [RM_TTAG_W-1:0] t_rd;
    logic [RM_TTAG_W-1:0] t_stale;
  } Rename_lane_t;

  // Identity mapping: architectural register idx lives in physical tag idx.
  function automatic int identity_tag(input int idx);
    return idx;
  endfunction

endpackage

// File: rtl/rename_bypass.sv
// Intra-group dependency resolution for one rename lane. A source (or the
// destination's stale name, or the T-bit name) takes the free-list tag of
// the youngest older lane in the group that writes it, else the map entry.
module rename_bypass
  import rename_map_pkg::*;
#(
  parameter int WIDTH  = RM_WIDTH,
  parameter int LANE   = 0,
  parameter int AW     = 4,
  parameter int PTAG_W = RM_PTAG_W,
  parameter int TTAG_W = RM_TTAG_W
) (
  input  logic [AW-1:0]                  rs1,
  input  logic [AW-1:0]                  rs2,
  input  logic [AW-1:0]                  rd,
  input  logic [PTAG_W-1:0]              map_rs1,
  input  logic [PTAG_W-1:0]              map_rs2,
  input  logic [PTAG_W-1:0]              map_rd,
  input  logic [TTAG_W-1:0]              map_t,
  input  logic [WIDTH-1:0]               wb,
  input  logic [WIDTH-1:0]               wb_t,
  input  logic [WIDTH-1:0][AW-1:0]       grp_rd,
  input  logic [WIDTH-1:0][PTAG_W-1:0]   grp_tag,
  input  logic [WIDTH-1:0][TTAG_W-1:0]   grp_t_tag,
  output logic [PTAG_W-1:0]              src1,
  output logic [PTAG_W-1:0]              src2,
  output logic [PTAG_W-1:0]              stale,
  output logic [TTAG_W-1:0]              t_src
);

  // Walk older lanes oldest-first so the youngest matching writer wins.
  always_comb begin
    src1  = map_rs1;
    src2  = map_rs2;
    stale = map_rd;
    t_src = map_t;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < LANE) begin
        if (wb[j] && (grp_rd[j] == rs1)) src1  = grp_tag[j];
        if (wb[j] && (grp_rd[j] == rs2)) src2  = grp_tag[j];
        if (wb[j] && (grp_rd[j] == rd))  stale = grp_tag[j];
        if (wb_t[j])                     t_src = grp_t_tag[j];
      end
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register rename stage: speculative and retirement maps for the
// architectural registers plus a single renamed T bit. Renames a group of
// up to WIDTH lanes per cycle with a registered, back-pressured output.
// Optional feature: define RENAME_CKPT_EN to add a one-deep map checkpoint
// (ckpt_take / ckpt_restore); without it recovery is by flush only.
module rename_map
  import rename_map_pkg::*;
#(
  parameter int WIDTH  = RM_WIDTH,
  parameter int NAREG  = RM_NAREG,
  parameter int PTAG_W = RM_PTAG_W,
  parameter int TTAG_W = RM_TTAG_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
`ifdef RENAME_CKPT_EN
  input  logic                                    ckpt_take,
  input  logic                                    ckpt_restore,
`endif
  input  logic [WIDTH-1:0]                        in_valid,
  input  logic [WIDTH-1:0][$clog2(NAREG)-1:0]     in_rs1,
  input  logic [WIDTH-1:0][$clog2(NAREG)-1:0]     in_rs2,
  input  logic [WIDTH-1:0][$clog2(NAREG)-1:0]     in_rd,
  input  logic [WIDTH-1:0]                        in_wb,
  input  logic [WIDTH-1:0]                        in_wb_t,
  input  logic [WIDTH-1:0][PTAG_W-1:0]            free_tag,
  input  logic [WIDTH-1:0][TTAG_W-1:0]            free_t_tag,
  output logic                                    in_ready,
  output logic [WIDTH-1:0]                        out_valid,
  input  logic                                    out_ready,
  output logic [WIDTH-1:0][PTAG_W-1:0]            p_rs1,
  output logic [WIDTH-1:0][PTAG_W-1:0]            p_rs2,
  output logic [WIDTH-1:0][PTAG_W-1:0]            p_rd,
  output logic [WIDTH-1:0][PTAG_W-1:0]            rd_stale,
  output logic [WIDTH-1:0][TTAG_W-1:0]            p_t,
  output logic [WIDTH-1:0][TTAG_W-1:0]            t_rd,
  output logic [WIDTH-1:0][TTAG_W-1:0]            t_stale,
  input  logic [WIDTH-1:0]                        ret_valid,
  input  logic [WIDTH-1:0][$clog2(NAREG)-1:0]     ret_rd,
  input  logic [WIDTH-1:0][PTAG_W-1:0]            ret_tag,
  input  logic [WIDTH-1:0]                        ret_t_valid,
  input  logic [WIDTH-1:0][TTAG_W-1:0]            ret_t_tag,
  input  logic                                    flush
);

  localparam int AW = $clog2(NAREG);

  logic [PTAG_W-1:0] spec_map [NAREG];
  logic [PTAG_W-1:0] ret_map  [NAREG];
  logic [PTAG_W-1:0] spec_upd [NAREG];
  logic [PTAG_W-1:0] ret_upd  [NAREG];
  logic [PTAG_W-1:0] spec_fin [NAREG];
  logic [TTAG_W-1:0] spec_t, ret_t, t_upd, ret_t_upd, t_fin;

  logic [WIDTH-1:0]             wb_v, wbt_v;
  logic [WIDTH-1:0][PTAG_W-1:0] byp_src1, byp_src2, byp_stale;
  logic [WIDTH-1:0][TTAG_W-1:0] byp_t;
  Rename_lane_t                 lane_d [WIDTH];
  Rename_lane_t                 lane_q [WIDTH];
  logic                         restore_hit;
  logic                         accept;

`ifdef RENAME_CKPT_EN
  logic [PTAG_W-1:0] ckpt_map [NAREG];
  logic [TTAG_W-1:0] ckpt_t;
  assign restore_hit = ckpt_restore;
`else
  assign restore_hit = 1'b0;
`endif

  // Writes from invalid lanes must never bypass or update the maps.
  assign wb_v     = in_wb & in_valid;
  assign wbt_v    = in_wb_t & in_valid;
  assign in_ready = !(|out_valid) || out_ready;
  assign accept   = in_ready && (|in_valid) && !flush && !restore_hit;

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    rename_bypass #(
      .WIDTH (WIDTH),
      .LANE  (k),
      .AW    (AW),
      .PTAG_W(PTAG_W),
      .TTAG_W(TTAG_W)
    ) u_bypass (
      .rs1      (in_rs1[k]),
      .rs2      (in_rs2[k]),
      .rd       (in_rd[k]),
      .map_rs1  (spec_map[in_rs1[k]]),
      .map_rs2  (spec_map[in_rs2[k]]),
      .map_rd   (spec_map[in_rd[k]]),
      .map_t    (spec_t),
      .wb       (wb_v),
      .wb_t     (wbt_v),
      .grp_rd   (in_rd),
      .grp_tag  (free_tag),
      .grp_t_tag(free_t_tag),
      .src1     (byp_src1[k]),
      .src2     (byp_src2[k]),
      .stale    (byp_stale[k]),
      .t_src    (byp_t[k])
    );
  end

  // Assemble the per-lane result record that will be registered on accept.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      lane_d[k].p_rs1    = byp_src1[k];
      lane_d[k].p_rs2    = byp_src2[k];
      lane_d[k].rd_stale = byp_stale[k];
      lane_d[k].p_rd     = in_wb[k]   ? free_tag[k]   : '0;
      lane_d[k].p_t      = in_wb_t[k] ? free_t_tag[k] : '0;
      lane_d[k].t_rd     = byp_t[k];
      lane_d[k].t_stale  = byp_t[k];
    end
  end

  // Speculative map after this group: later lanes overwrite earlier ones.
  always_comb begin
    spec_upd = spec_map;
    t_upd    = spec_t;
    for (int k = 0; k < WIDTH; k++) begin
      if (wb_v[k])  spec_upd[in_rd[k]] = free_tag[k];
      if (wbt_v[k]) t_upd = free_t_tag[k];
    end
  end

  // Retirement map after this cycle's retirements, applied oldest-first.
  always_comb begin
    ret_upd   = ret_map;
    ret_t_upd = ret_t;
    for (int k = 0; k < WIDTH; k++) begin
      if (ret_valid[k])   ret_upd[ret_rd[k]] = ret_tag[k];
      if (ret_t_valid[k]) ret_t_upd = ret_t_tag[k];
    end
  end

  // Next speculative map: flush beats checkpoint restore beats rename.
  always_comb begin
    spec_fin = spec_map;
    t_fin    = spec_t;
    if (flush) begin
      spec_fin = ret_upd;
      t_fin    = ret_t_upd;
    end
`ifdef RENAME_CKPT_EN
    else if (ckpt_restore) begin
      spec_fin = ckpt_map;
      t_fin    = ckpt_t;
    end
`endif
    else if (accept) begin
      spec_fin = spec_upd;
      t_fin    = t_upd;
    end
  end

  // Map state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NAREG; i++) begin
        spec_map[i] <= PTAG_W'(identity_tag(i));
        ret_map[i]  <= PTAG_W'(identity_tag(i));
      end
      spec_t <= '0;
      ret_t  <= '0;
    end else begin
      spec_map <= spec_fin;
      spec_t   <= t_fin;
      ret_map  <= ret_upd;
      ret_t    <= ret_t_upd;
    end
  end

`ifdef RENAME_CKPT_EN
  // Snapshot the map as it stands after this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NAREG; i++) ckpt_map[i] <= PTAG_W'(identity_tag(i));
      ckpt_t <= '0;
    end else if (ckpt_take) begin
      ckpt_map <= spec_fin;
      ckpt_t   <= t_fin;
    end
  end
`endif

  // Output stage: load on accept, hold under back-pressure, drain on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      for (int k = 0; k < WIDTH; k++) lane_q[k] <= '0;
    end else if (flush || restore_hit) begin
      out_valid <= '0;
    end else if (accept) begin
      out_valid <= in_valid;
      lane_q    <= lane_d;
    end else if (out_ready) begin
      out_valid <= '0;
    end
  end

  // Unpack the registered lane records onto the output buses.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      p_rs1[k]    = lane_q[k].p_rs1;
      p_rs2[k]    = lane_q[k].p_rs2;
      p_rd[k]     = lane_q[k].p_rd;
      rd_stale[k] = lane_q[k].rd_stale;
      p_t[k]      = lane_q[k].p_t;
      t_rd[k]     = lane_q[k].t_rd;
      t_stale[k]  = lane_q[k].t_stale;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map with a sequential-rename reference model.
// Build with RENAME_CKPT_EN defined to also cover the checkpoint feature.
module tb_rename_map;

  localparam int W  = 2;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int PT = 5;
  localparam int TT = 4;

  logic clk = 1'b0;
  logic rst;
  logic ck_take, ck_restore;
  logic [W-1:0]          in_valid, in_wb, in_wb_t;
  logic [W-1:0][AW-1:0]  in_rs1, in_rs2, in_rd;
  logic [W-1:0][PT-1:0]  free_tag;
  logic [W-1:0][TT-1:0]  free_t_tag;
  logic                  in_ready;
  logic [W-1:0]          out_valid;
  logic                  out_ready;
  logic [W-1:0][PT-1:0]  p_rs1, p_rs2, p_rd, rd_stale;
  logic [W-1:0][TT-1:0]  p_t, t_rd, t_stale;
  logic [W-1:0]          ret_valid, ret_t_valid;
  logic [W-1:0][AW-1:0]  ret_rd;
  logic [W-1:0][PT-1:0]  ret_tag;
  logic [W-1:0][TT-1:0]  ret_t_tag;
  logic                  flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_map #(.WIDTH(W), .NAREG(NR), .PTAG_W(PT), .TTAG_W(TT)) dut (
    .clk(clk), .rst(rst),
`ifdef RENAME_CKPT_EN
    .ckpt_take(ck_take), .ckpt_restore(ck_restore),
`endif
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_wb(in_wb), .in_wb_t(in_wb_t), .free_tag(free_tag), .free_t_tag(free_t_tag),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .p_rs1(p_rs1), .p_rs2(p_rs2), .p_rd(p_rd), .rd_stale(rd_stale),
    .p_t(p_t), .t_rd(t_rd), .t_stale(t_stale),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_tag(ret_tag),
    .ret_t_valid(ret_t_valid), .ret_t_tag(ret_t_tag), .flush(flush)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_spec[NR], m_ret[NR], m_ck[NR];
  int m_t, m_rt, m_ckt;
  bit [W-1:0] e_valid;
  int e_rs1[W], e_rs2[W], e_prd[W], e_stale[W], e_pt[W], e_trd[W], e_tst[W];

  // Rename lanes one after another against a working copy of the map.
  always @(posedge clk) begin
    int tmp[NR];
    int rn[NR];
    int tt, rnt;
    bit rdy;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_spec[i] = i; m_ret[i] = i; m_ck[i] = i;
      end
      m_t = 0; m_rt = 0; m_ckt = 0;
      e_valid = '0;
    end else begin
      rn = m_ret; rnt = m_rt;
      for (int k = 0; k < W; k++) begin
        if (ret_valid[k]) rn[ret_rd[k]] = int'(ret_tag[k]);
        if (ret_t_valid[k]) rnt = int'(ret_t_tag[k]);
      end
      rdy = (e_valid == 0) || out_ready;
      if (flush) begin
        m_spec = rn; m_t = rnt; e_valid = '0;
      end else if (ck_restore) begin
        m_spec = m_ck; m_t = m_ckt; e_valid = '0;
      end else if (rdy && in_valid != 0) begin
        tmp = m_spec; tt = m_t;
        for (int k = 0; k < W; k++) begin
          if (in_valid[k]) begin
            e_rs1[k]   = tmp[in_rs1[k]];
            e_rs2[k]   = tmp[in_rs2[k]];
            e_stale[k] = tmp[in_rd[k]];
            e_trd[k]   = tt;
            e_tst[k]   = tt;
            e_prd[k]   = in_wb[k]   ? int'(free_tag[k])   : 0;
            e_pt[k]    = in_wb_t[k] ? int'(free_t_tag[k]) : 0;
            if (in_wb[k])   tmp[in_rd[k]] = int'(free_tag[k]);
            if (in_wb_t[k]) tt = int'(free_t_tag[k]);
          end
        end
        m_spec = tmp; m_t = tt; e_valid = in_valid;
      end else if (out_ready) begin
        e_valid = '0;
      end
      if (ck_take) begin
        m_ck = m_spec; m_ckt = m_t;
      end
      m_ret = rn; m_rt = rnt;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(in_ready), int'((e_valid == 0) || out_ready));
      chk("out_valid", int'(out_valid), int'(e_valid));
      for (int k = 0; k < W; k++) begin
        if (e_valid[k]) begin
          chk($sformatf("p_rs1[%0d]", k), int'(p_rs1[k]), e_rs1[k]);
          chk($sformatf("p_rs2[%0d]", k), int'(p_rs2[k]), e_rs2[k]);
          chk($sformatf("p_rd[%0d]", k), int'(p_rd[k]), e_prd[k]);
          chk($sformatf("rd_stale[%0d]", k), int'(rd_stale[k]), e_stale[k]);
          chk($sformatf("p_t[%0d]", k), int'(p_t[k]), e_pt[k]);
          chk($sformatf("t_rd[%0d]", k), int'(t_rd[k]), e_trd[k]);
          chk($sformatf("t_stale[%0d]", k), int'(t_stale[k]), e_tst[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    in_valid = '0; in_wb = '0; in_wb_t = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    free_tag = '0; free_t_tag = '0;
    ret_valid = '0; ret_t_valid = '0; ret_rd = '0; ret_tag = '0; ret_t_tag = '0;
    flush = 1'b0; ck_take = 1'b0; ck_restore = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic ln(input int k, input int rs1, input int rs2, input int rd,
                    input bit wb, input int tag, input bit wbt, input int ttag);
    in_valid[k]   = 1'b1;
    in_rs1[k]     = AW'(rs1);
    in_rs2[k]     = AW'(rs2);
    in_rd[k]      = AW'(rd);
    in_wb[k]      = wb;
    free_tag[k]   = PT'(tag);
    in_wb_t[k]    = wbt;
    free_t_tag[k] = TT'(ttag);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // First rename after reset reads identity names.
    ln(0, 1, 2, 3, 1, 20, 0, 0); tick();
    chk("r032_p_rs1", int'(p_rs1[0]), 1);
    chk("r032_p_rs2", int'(p_rs2[0]), 2);
    chk("r032_p_rd", int'(p_rd[0]), 20);
    chk("r032_stale", int'(rd_stale[0]), 3);

    clr(); flush = 1'b1; tick();
    chk("flush1_out_valid", int'(out_valid), 0);

    // Same-group write-after-write and read-after-write on r3.
    clr(); ln(0, 0, 0, 3, 1, 20, 0, 0); ln(1, 3, 0, 3, 1, 21, 0, 0); tick();
    chk("r033_l0_stale", int'(rd_stale[0]), 3);
    chk("r033_l1_p_rs1", int'(p_rs1[1]), 20);
    chk("r033_l1_stale", int'(rd_stale[1]), 20);
    chk("r033_l1_p_rd", int'(p_rd[1]), 21);

    clr(); ln(0, 3, 0, 7, 1, 23, 0, 0); tick();
    chk("r033_map3", int'(p_rs1[0]), 21);

    // Back-pressure for three cycles with a new group waiting.
    clr(); out_ready = 1'b0; ln(0, 3, 0, 3, 1, 24, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r034_in_ready", int'(in_ready), 0);
      chk("r034_hold_p_rd", int'(p_rd[0]), 23);
      chk("r034_hold_p_rs1", int'(p_rs1[0]), 21);
    end
    out_ready = 1'b1; tick();
    chk("r034_after_rs1", int'(p_rs1[0]), 21);
    chk("r034_after_stale", int'(rd_stale[0]), 21);
    chk("r034_after_p_rd", int'(p_rd[0]), 24);

    // Flush discards speculative renames.
    clr(); ln(0, 0, 0, 5, 1, 22, 0, 0); tick();
    clr(); flush = 1'b1; tick();
    chk("r035_out_valid", int'(out_valid), 0);
    clr(); ln(0, 5, 3, 0, 0, 0, 0, 0); tick();
    chk("r035_p_rs1", int'(p_rs1[0]), 5);
    chk("r035_p_rs2", int'(p_rs2[0]), 3);
    chk("r035_p_rd_nowb", int'(p_rd[0]), 0);

    // Two retirements to the same register with a same-cycle flush.
    clr(); flush = 1'b1;
    ret_valid = 2'b11; ret_rd[0] = 4'd4; ret_tag[0] = 5'd9;
    ret_rd[1] = 4'd4; ret_tag[1] = 5'd11;
    ret_t_valid = 2'b11; ret_t_tag[0] = 4'd2; ret_t_tag[1] = 4'd3;
    tick();
    clr(); ln(0, 4, 0, 0, 0, 0, 0, 0); tick();
    chk("r036_map4", int'(p_rs1[0]), 11);
    chk("r036_t", int'(t_rd[0]), 3);

    // T-bit bypass; a non-writing rd must not bypass.
    clr(); ln(0, 0, 0, 1, 0, 0, 1, 5); ln(1, 1, 0, 2, 0, 0, 0, 0); tick();
    chk("t_l0_t_rd", int'(t_rd[0]), 3);
    chk("t_l0_p_t", int'(p_t[0]), 5);
    chk("t_l0_p_rd", int'(p_rd[0]), 0);
    chk("t_l1_t_rd", int'(t_rd[1]), 5);
    chk("t_l1_p_t", int'(p_t[1]), 0);
    chk("t_l1_p_rs1", int'(p_rs1[1]), 1);

    // Single-lane group, then flush colliding with a presented group.
    clr(); ln(0, 2, 2, 2, 1, 26, 0, 0); tick();
    chk("one_lane_valid", int'(out_valid), 1);
    chk("one_lane_stale", int'(rd_stale[0]), 2);
    clr(); ln(0, 0, 0, 8, 1, 27, 0, 0); flush = 1'b1; tick();
    chk("flush_prio_valid", int'(out_valid), 0);
    clr(); ln(0, 8, 2, 0, 0, 0, 0, 0); tick();
    chk("flush_prio_r8", int'(p_rs1[0]), 8);
    chk("flush_prio_r2", int'(p_rs2[0]), 2);

    // Reset while an output is stalled.
    clr(); ln(0, 0, 0, 9, 1, 28, 0, 0); tick();
    clr(); out_ready = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; clr();
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    ln(0, 9, 4, 0, 0, 0, 0, 0); tick();
    chk("rst2_r9", int'(p_rs1[0]), 9);
    chk("rst2_r4", int'(p_rs2[0]), 4);
    chk("rst2_t", int'(t_rd[0]), 0);

`ifdef RENAME_CKPT_EN
    clr(); ck_take = 1'b1; tick();
    clr(); ln(0, 0, 0, 6, 1, 25, 0, 0); tick();
    chk("r037_p_rd", int'(p_rd[0]), 25);
    clr(); ck_restore = 1'b1; ln(0, 6, 0, 0, 0, 0, 0, 0); tick();
    chk("r037_restore_valid", int'(out_valid), 0);
    clr(); ln(0, 6, 0, 0, 0, 0, 0, 0); tick();
    chk("r037_r6", int'(p_rs1[0]), 6);
    clr(); ln(0, 0, 0, 10, 1, 29, 0, 0); ck_take = 1'b1; tick();
    clr(); ln(0, 0, 0, 10, 1, 30, 0, 0); tick();
    clr(); ck_restore = 1'b1; tick();
    clr(); ln(0, 10, 0, 0, 0, 0, 0, 0); tick();
    chk("ckpt_post_update", int'(p_rs1[0]), 29);
`endif

    clr(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rename_map.md
RENAME_MAP -- requirements
Module: rename_map

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of rename lanes per cycle (1..4).
REQ-002 SHALL have parameter NAREG, default 16, number of architectural registers (D0-D7, A0-A7).
REQ-003 SHALL have parameter PTAG_W, default 5, physical register tag width.
REQ-004 SHALL have parameter TTAG_W, default 4, physical T-bit tag width.
REQ-005 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock, reset synchronous and active-high.
REQ-006 SHALL have in_valid (input, WIDTH), lane valids, thermometer-coded from lane 0.
REQ-007 SHALL have in_rs1, in_rs2, in_rd (input, WIDTH x log2(NAREG)), architectural register indices per lane.
REQ-008 SHALL have in_wb and in_wb_t (input, WIDTH), register and T-bit writeback flags.
REQ-009 SHALL have free_tag (input, WIDTH x PTAG_W) and free_t_tag (input, WIDTH x TTAG_W), free-list names per lane.
REQ-010 SHALL have in_ready (output, 1), group accepted this cycle.
REQ-011 SHALL have out_valid (output, WIDTH), out_ready (input, 1), and p_rs1, p_rs2, p_rd, rd_stale (output, WIDTH x PTAG_W).
REQ-012 SHALL have p_t, t_rd, t_stale (output, WIDTH x TTAG_W).
REQ-013 SHALL have ret_valid (input, WIDTH), ret_rd (input, WIDTH x log2(NAREG)), ret_tag (input, WIDTH x PTAG_W), ret_t_valid (input, WIDTH), ret_t_tag (input, WIDTH x TTAG_W); retirement updates, oldest lane 0.
REQ-014 SHALL have flush (input, 1), restoring the speculative map from the retirement map.

Function
REQ-015 SHALL assert in_ready = !(|out_valid) | out_ready, and SHALL accept the whole group or none of it.
REQ-016 SHALL register outputs with 1-cycle latency; outputs SHALL hold stable while out_valid is set and out_ready is low.
REQ-017 For a lane k source, SHALL use the free_tag of the youngest lane j<k with in_wb and in_rd==source; otherwise the speculative map entry.
REQ-018 SHALL apply the REQ-017 rule to rd_stale (against in_rd[k]) and to t_rd/t_stale (youngest older lane with in_wb_t, else the T map).
REQ-019 On accept, SHALL write each arch register written in the group with the youngest writer's tag only; T map likewise.
REQ-020 SHALL drive p_rd=free_tag[k] and p_t=free_t_tag[k] when the lane writes; SHALL drive 0 when it does not.
REQ-021 SHALL update the retirement map in lane order every cycle; the youngest lane SHALL win on equal ret_rd.
REQ-022 On flush, SHALL clear out_valid, ignore inputs, and set spec map = retirement map including same-cycle retirements.
REQ-023 SHALL give flush priority over checkpoint restore, and restore priority over rename.

Reset
REQ-024 On rst, SHALL set spec and retirement maps to identity (entry i = i), T maps to 0, and out_valid to 0.
REQ-025 On rst, SHALL set in_ready to 1 in the following cycle, and SHALL discard any operation in progress when reset is asserted.

Configuration
REQ-026 With RENAME_CKPT_EN defined, SHALL add ports ckpt_take and ckpt_restore (input, 1).
REQ-027 With RENAME_CKPT_EN, ckpt_take SHALL snapshot the post-update spec and T maps.
REQ-028 With RENAME_CKPT_EN, ckpt_restore SHALL reload the snapshot in one cycle and clear out_valid.
REQ-029 Without RENAME_CKPT_EN, SHALL omit the ports and snapshot storage; recovery SHALL occur only by flush.

Structure
REQ-030 SHALL place the parameter defaults, the Rename_lane_t typedef (per-lane outputs) and the identity-map initialiser function in the shared package.
REQ-031 SHALL instantiate sub-module rename_bypass once per lane to implement the REQ-017/018 youngest-older-writer selection.

Verification
REQ-032 After reset, lane0 ADD rs1=1 rs2=2 rd=3 with free_tag=20 -> next cycle p_rs1=1, p_rs2=2, p_rd=20, rd_stale=3.
REQ-033 Lane0 rd=3 (tag 20), lane1 rs1=3 rd=3 (tag 21) -> lane1 p_rs1=20, rd_stale=20; map[3]=21.
REQ-034 out_ready=0 for 3 cycles with valid output -> in_ready=0, outputs unchanged, map unchanged.
REQ-035 Rename rd=5->22, retire nothing, flush -> out_valid=0; the next rename reading r5 gives p_rs1=5.
REQ-036 Retire lane0 rd=4 tag 9 and lane1 rd=4 tag 11, flush in the same cycle -> spec map[4]=11.
REQ-037 With RENAME_CKPT_EN: ckpt_take, rename rd=6->25, then ckpt_restore -> next read of r6 gives 6.
